// File: rtl/if_stage.sv
// Instruction-fetch stage: generates nextpc, drives the instruction SRAM, and
// hands {inst, pc} to ID under a valid/allowin handshake with branch redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic [32:0] br_zip,
  output logic        fs2ds_valid,
  output logic [63:0] fs2ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  localparam int unsigned XLEN = 32;

  logic            r_fs_valid;
  logic [XLEN-1:0] r_fs_pc;
  logic [XLEN-1:0] r_inst_buf;
  logic            r_buf_valid;
  logic            r_br_pending;
  logic [XLEN-1:0] r_pend_target;

  logic            w_br_taken;
  logic [XLEN-1:0] w_br_target;
  logic            w_fs_ready_go;
  logic            w_fs_allowin;
  logic [XLEN-1:0] w_nextpc;
  logic [XLEN-1:0] w_fs_inst;

  assign w_br_taken    = br_zip[32];
  assign w_br_target   = br_zip[31:0];
  assign w_fs_ready_go = 1'b1;
  assign w_fs_allowin  = ~r_fs_valid | (ds_allowin & w_fs_ready_go);

  // A live redirect beats a redirect deferred from a stalled cycle.
  assign w_nextpc = w_br_taken   ? w_br_target   :
                    r_br_pending ? r_pend_target :
                                   r_fs_pc + XLEN'(4);

  // SRAM data is only valid the cycle after the read; the buffer covers ID stalls.
  assign w_fs_inst = ~r_fs_valid ? '0 :
                     r_buf_valid ? r_inst_buf : inst_sram_rdata;

  assign fs2ds_valid     = r_fs_valid & w_fs_ready_go & ~w_br_taken;
  assign fs2ds_bus       = {w_fs_inst, r_fs_pc};
  assign inst_sram_en    = resetn & w_fs_allowin;
  assign inst_sram_addr  = w_nextpc;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fs_valid    <= 1'b0;
      r_fs_pc       <= XLEN'(RESET_PC - 32'd4);
      r_inst_buf    <= '0;
      r_buf_valid   <= 1'b0;
      r_br_pending  <= 1'b0;
      r_pend_target <= '0;
    end else if (w_fs_allowin) begin
      r_fs_valid   <= 1'b1;
      r_fs_pc      <= w_nextpc;
      r_buf_valid  <= 1'b0;
      r_br_pending <= 1'b0;
    end else if (w_br_taken) begin
      // Stalled redirect: squash the wrong-path inst, fetch the target next cycle.
      r_pend_target <= w_br_target;
      r_br_pending  <= 1'b1;
      r_fs_valid    <= 1'b0;
      r_buf_valid   <= 1'b0;
    end else if (r_fs_valid && !r_buf_valid) begin
      r_inst_buf  <= inst_sram_rdata;
      r_buf_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: an instruction-level reference model predicts
// which pc is presented and that its inst equals the memory image at that pc.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk;
  logic        resetn;
  logic        ds_allowin;
  logic [32:0] br_zip;
  logic        fs2ds_valid;
  logic [63:0] fs2ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds_allowin      (ds_allowin),
    .br_zip          (br_zip),
    .fs2ds_valid     (fs2ds_valid),
    .fs2ds_bus       (fs2ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A50000;
  endfunction

  // Memory image appears one cycle after an enabled read; otherwise garbage.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr);
    else              inst_sram_rdata <= $urandom() | 32'h1;
  end

  // Reference model: what instruction is held, and any deferred redirect.
  bit          m_valid = 1'b0;
  logic [31:0] m_pc    = RESET_PC - 32'd4;
  logic [31:0] m_pend_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic rn, input logic da, input logic bt,
                       input logic [31:0] tg, input bit do_chk);
    bit          allow;
    logic [31:0] addr;
    logic [63:0] bus;
    @(negedge clk);
    resetn     = rn;
    ds_allowin = da;
    br_zip     = {bt, tg};
    #1;
    allow = !m_valid || da;
    if (bt)                    addr = tg;
    else if (m_pend_q.size()) addr = m_pend_q[0];
    else                       addr = m_pc + 32'd4;
    bus = {(m_valid ? mem(m_pc) : 32'h0), m_pc};
    if (do_chk) begin
      chk("valid", 64'(fs2ds_valid), 64'(m_valid && !bt));
      chk("bus",   fs2ds_bus, bus);
      chk("en",    64'(inst_sram_en), 64'(rn && allow));
      chk("addr",  64'(inst_sram_addr), 64'(addr));
      chk("we_wdata", {28'h0, inst_sram_we, inst_sram_wdata}, 64'h0);
    end
    if (!rn) begin
      m_valid = 1'b0;
      m_pc    = RESET_PC - 32'd4;
      m_pend_q.delete();
    end else if (allow) begin
      m_valid = 1'b1;
      m_pc    = addr;
      m_pend_q.delete();
    end else if (bt) begin
      m_valid = 1'b0;
      m_pend_q.delete();
      m_pend_q.push_back(tg);
    end
  endtask

  initial begin
    logic [31:0] tg;
    bit          bt;
    resetn     = 1'b0;
    ds_allowin = 1'b1;
    br_zip     = '0;
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    // Reset release and steady fetch
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    // ID stall with garbage on rdata, then release
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    // Redirect while accepting
    cycle(1'b1, 1'b1, 1'b1, 32'h1c000100, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    // Redirect while stalled
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'h1c000200, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    // Reset with buffered inst, then reset with pending redirect
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'h1c000300, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    // pc wrap at the top of the address space
    cycle(1'b1, 1'b1, 1'b1, 32'hfffffffc, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      bt = ($urandom_range(0, 99) < 15);
      case ($urandom_range(0, 3))
        0:       tg = 32'hfffffffc;
        1:       tg = {$urandom_range(0, 255) << 2} + 32'h1c000000;
        default: tg = $urandom() & 32'hfffffffc;
      endcase
      cycle(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 65), bt, tg, 1'b1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
